nonce_sweep_scheduler: RTL and testbench
========================================

// Module: nonce_sweep_scheduler
// PURPOSE
//  Sequences a 16-nonce bitcoin_hash core across a nonce range [nonce_first, nonce_last].
//  Per batch: hand the core a base nonce, pulse start, wait for done.
//  Then take over the shared memory port, read the NUM_NONCES result words and compare each to target.
//  Stops at the first hit, or at range end. Sits between the host/control registers and the hash core + memory.
// PARAMETERS
//  NUM_NONCES  16  nonces per core pass; result words per batch; base step
//  IDX_W       4   width of result index, = clog2(NUM_NONCES)
// PORTS
//  clk             in   1   clock, shared with core and memory
//  reset_n         in   1   async active-low reset
//  sweep_start     in   1   1-cycle pulse; accepted only in IDLE
//  abort           in   1   level; ends sweep early (see BEHAVIOUR)
//  nonce_first     in   32  first nonce of range; sampled on sweep_start
//  nonce_last      in   32  last nonce of range, inclusive; sampled on sweep_start
//  target          in   32  hit when result word < target (unsigned); sampled on sweep_start
//  output_addr     in   16  memory base where core writes its NUM_NONCES results
//  core_start      out  1   1-cycle start pulse to hash core
//  core_nonce_base out  32  nonce of core lane 0; lane n uses base+n
//  core_done       in   1   core done level
//  mem_sel         out  1   1 = scheduler owns memory port, 0 = core owns it
//  mem_addr        out  16  read address while mem_sel=1
//  mem_read_data   in   32  read data, valid 1 cycle after address
//  busy            out  1   high from sweep_start accept to sweep_done
//  sweep_done      out  1   1-cycle pulse at end of sweep (hit, exhausted or abort)
//  found           out  1   valid with sweep_done; held until next accepted sweep_start
//  found_nonce     out  32  winning nonce; held with found
//  found_hash      out  32  winning result word; held with found
//  batch_count     out  16  batches completed this sweep; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; mem_sel 0.
//  States: IDLE -> LAUNCH -> WAIT_CORE -> RD_ADDR -> RD_CMP -> (LAUNCH | FINISH) -> IDLE; DRAIN for abort.
//  IDLE
//   - On sweep_start, latch nonce_first/nonce_last/target.
//   - Set base=nonce_first; clear found/found_nonce/found_hash/batch_count; busy=1; -> LAUNCH.
//  LAUNCH
//   - core_start=1 for exactly one cycle; core_nonce_base=base, stable until next LAUNCH; -> WAIT_CORE.
//  WAIT_CORE
//   - Wait for a registered 0->1 edge of core_done after the launch; a stale high done is ignored.
//   - On the edge: mem_sel<=1, idx<=0 -> RD_ADDR.
//  RD_ADDR/RD_CMP pipeline
//   - Address output_addr+idx issued in cycle t; data compared in cycle t+1.
//   - Addresses are issued back-to-back, so a batch readback takes NUM_NONCES+1 cycles.
//  Compare
//   - Lane idx qualifies if (base+idx) <= nonce_last, using a 33-bit compare (no wrap).
//   - Lane idx hits if it qualifies and mem_read_data < target.
//   - First hit (lowest idx) wins: latch found=1, found_nonce=base+idx, found_hash=data; later lanes ignored.
//  Batch end
//   - mem_sel<=0; batch_count+1.
//   - Go to FINISH if found, or if base+NUM_NONCES > nonce_last (33-bit), or if base+NUM_NONCES wraps past 2^32-1.
//   - Otherwise base+=NUM_NONCES and go to LAUNCH.
//  FINISH
//   - sweep_done=1 for one cycle; busy<=0; -> IDLE.
//  Range edge cases
//   - nonce_last < nonce_first: one batch runs, no lane qualifies, found=0.
//   - target=0: never hits.
//  abort
//   - In LAUNCH/RD_*: go to FINISH next cycle, found=0, mem_sel<=0.
//   - In WAIT_CORE: go to DRAIN; wait for the core_done edge, then FINISH (the core cannot be stopped).
//   - Ignored in IDLE.
//  Other edges
//   - sweep_start while busy is ignored.
//   - reset_n low mid-sweep: immediate IDLE; mem_sel=0; core_start=0.
//  Port ownership: mem_sel=1 only in RD_ADDR/RD_CMP; never overlaps core_start or WAIT_CORE.
// TESTING
//  1 first=0,last=15,target=FFFFFFFF, core model writes any data
//     -> 1 batch, found=1, found_nonce=0, batch_count=1.
//  2 first=0,last=47,target=00001000; batch1 lane 5 = 00000FFF, lane 9 = 00000001
//     -> found_nonce=21, found_hash=00000FFF, batch_count=2, only 2 core_start pulses.
//  3 first=FFFFFFF0,last=FFFFFFFF, no hit
//     -> exactly 1 batch, found=0, sweep_done after readback, no base wrap.
//  4 first=10,last=20,target=FFFFFFFF, first batch lanes all hit
//     -> found_nonce=10; second check: lanes with nonce>20 masked, e.g. base=16 only lanes 0..4 compared.
//  5 abort asserted 3 cycles into WAIT_CORE
//     -> no mem_sel, sweep_done only after core_done edge, found=0.
//  6 reset_n pulsed during RD_CMP
//     -> all outputs 0 same cycle; new sweep_start afterwards runs normally.

Source files
------------

// File: rtl/nonce_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_sweep_scheduler
//
// Purpose:
//   Drives a NUM_NONCES-lane hash core across an inclusive nonce range.
//   For each batch it launches the core on a base nonce, waits for the core to
//   finish, then takes the shared memory port and reads back the NUM_NONCES
//   result words. Each qualifying lane (nonce inside the range) whose word is
//   below target is a hit. The lowest hit lane wins. The sweep ends on a hit,
//   at range end, or on abort.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   sweep_start         1-cycle request, accepted only when idle
//   abort               level, ends the sweep early
//   nonce_first/last    inclusive nonce range, sampled on sweep_start
//   target              hit threshold (word < target), sampled on sweep_start
//   output_addr         memory base of the core's result block
//   core_start          1-cycle launch pulse to the core
//   core_nonce_base     nonce of core lane 0
//   core_done           core completion level
//   mem_sel             1 = scheduler owns the memory port
//   mem_addr            read address while mem_sel = 1
//   mem_read_data       read data, one cycle after its address
//   busy                sweep in progress
//   sweep_done          1-cycle end-of-sweep pulse
//   found, found_nonce, found_hash   result, held until the next sweep
//   batch_count         completed batches, saturating
// -----------------------------------------------------------------------------
module nonce_sweep_scheduler #(
  parameter int NUM_NONCES = 16,
  parameter int IDX_W      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sweep_start,
  input  logic        abort,
  input  logic [31:0] nonce_first,
  input  logic [31:0] nonce_last,
  input  logic [31:0] target,
  input  logic [15:0] output_addr,
  output logic        core_start,
  output logic [31:0] core_nonce_base,
  input  logic        core_done,
  output logic        mem_sel,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        sweep_done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic [31:0] found_hash,
  output logic [15:0] batch_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_CMP  = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(NUM_NONCES);
  localparam logic [32:0]    STEP_33  = 33'(NUM_NONCES);

  logic [2:0]       state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      last_q, last_d;
  logic [31:0]      target_q, target_d;
  // idx_q is the address index being issued; the lane compared in the same
  // cycle is idx_q-1 because read data lags its address by one cycle.
  logic [IDX_W:0]   idx_q, idx_d;
  logic             mem_sel_q, mem_sel_d;
  logic             busy_q, busy_d;
  logic             found_q, found_d;
  logic [31:0]      found_nonce_q, found_nonce_d;
  logic [31:0]      found_hash_q, found_hash_d;
  logic [15:0]      batch_count_q, batch_count_d;
  logic             done_q;

  logic             done_rise;
  logic [IDX_W:0]   lane_idx;
  logic [32:0]      lane_nonce_33;
  logic             lane_ok;
  logic             lane_hit;
  logic [32:0]      next_base_33;
  logic             range_end;

  // Only a fresh rising edge counts, so a done level left high from the
  // previous batch cannot be mistaken for completion of the new one.
  assign done_rise = core_done && !done_q;

  assign lane_idx      = idx_q - 1'b1;
  assign lane_nonce_33 = {1'b0, base_q} + 33'(lane_idx);
  assign lane_ok       = (lane_nonce_33 <= {1'b0, last_q});
  assign lane_hit      = lane_ok && (mem_read_data < target_q) && !found_q;

  // 33-bit sum: bit 32 set means the next base would wrap past 2^32-1.
  assign next_base_33 = {1'b0, base_q} + STEP_33;
  assign range_end    = (next_base_33 > {1'b0, last_q}) || next_base_33[32];

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    last_d        = last_q;
    target_d      = target_q;
    idx_d         = idx_q;
    mem_sel_d     = mem_sel_q;
    busy_d        = busy_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    batch_count_d = batch_count_q;

    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          base_d        = nonce_first;
          last_d        = nonce_last;
          target_d      = target;
          found_d       = 1'b0;
          found_nonce_d = '0;
          found_hash_d  = '0;
          batch_count_d = '0;
          busy_d        = 1'b1;
          state_d       = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        state_d = abort ? S_FINISH : S_WAIT;
      end

      S_WAIT: begin
        if (done_rise) begin
          // Core already finished: nothing left to drain on abort.
          if (abort) begin
            state_d = S_FINISH;
          end else begin
            mem_sel_d = 1'b1;
            idx_d     = '0;
            state_d   = S_RD_ADDR;
          end
        end else if (abort) begin
          // The core cannot be stopped; let it finish before releasing.
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (done_rise) begin
          state_d = S_FINISH;
        end
      end

      S_RD_ADDR: begin
        if (abort) begin
          mem_sel_d = 1'b0;
          state_d   = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD_CMP;
        end
      end

      S_RD_CMP: begin
        if (abort) begin
          mem_sel_d     = 1'b0;
          found_d       = 1'b0;
          found_nonce_d = '0;
          found_hash_d  = '0;
          state_d       = S_FINISH;
        end else begin
          if (lane_hit) begin
            found_d       = 1'b1;
            found_nonce_d = lane_nonce_33[31:0];
            found_hash_d  = mem_read_data;
          end
          if (idx_q == LAST_IDX) begin
            mem_sel_d = 1'b0;
            if (batch_count_q != 16'hFFFF) begin
              batch_count_d = batch_count_q + 16'd1;
            end
            if (found_q || lane_hit || range_end) begin
              state_d = S_FINISH;
            end else begin
              base_d  = next_base_33[31:0];
              state_d = S_LAUNCH;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      last_q        <= '0;
      target_q      <= '0;
      idx_q         <= '0;
      mem_sel_q     <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      batch_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      last_q        <= last_d;
      target_q      <= target_d;
      idx_q         <= idx_d;
      mem_sel_q     <= mem_sel_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      batch_count_q <= batch_count_d;
      done_q        <= core_done;
    end
  end

  assign core_start      = (state_q == S_LAUNCH);
  assign sweep_done      = (state_q == S_FINISH);
  assign core_nonce_base = base_q;
  assign mem_sel         = mem_sel_q;
  // On the final compare cycle idx_q points one past the block; that extra
  // read is never used.
  assign mem_addr        = mem_sel_q ? (output_addr + 16'(idx_q)) : 16'd0;
  assign busy            = busy_q;
  assign found           = found_q;
  assign found_nonce     = found_nonce_q;
  assign found_hash      = found_hash_q;
  assign batch_count     = batch_count_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
module tb_nonce_sweep_scheduler;

  localparam logic [15:0] OUT_ADDR = 16'h0040;
  localparam int          CORE_LAT = 8;

  typedef struct {
    logic        found;
    logic [31:0] nonce;
    logic [31:0] hash;
    logic [15:0] batches;
    int          starts;
    int          memcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sweep_start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] nonce_first = '0;
  logic [31:0] nonce_last = '0;
  logic [31:0] target = '0;
  logic [15:0] output_addr = OUT_ADDR;
  logic        core_start;
  logic [31:0] core_nonce_base;
  logic        core_done = 1'b0;
  logic        mem_sel;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data = '0;
  logic        busy;
  logic        sweep_done;
  logic        found;
  logic [31:0] found_nonce;
  logic [31:0] found_hash;
  logic [15:0] batch_count;

  int errors = 0;
  int checks = 0;
  int pattern = 0;
  int sweep_no = 0;
  exp_t exp_q[$];

  nonce_sweep_scheduler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sweep_start     (sweep_start),
    .abort           (abort),
    .nonce_first     (nonce_first),
    .nonce_last      (nonce_last),
    .target          (target),
    .output_addr     (output_addr),
    .core_start      (core_start),
    .core_nonce_base (core_nonce_base),
    .core_done       (core_done),
    .mem_sel         (mem_sel),
    .mem_addr        (mem_addr),
    .mem_read_data   (mem_read_data),
    .busy            (busy),
    .sweep_done      (sweep_done),
    .found           (found),
    .found_nonce     (found_nonce),
    .found_hash      (found_hash),
    .batch_count     (batch_count)
  );

  always #5 clk = ~clk;

  // Result word the core model produces for a given nonce.
  function automatic logic [31:0] word_of(input logic [31:0] n, input int p);
    case (p)
      0:       return 32'h0000_1000 + n;
      1:       return (n == 32'd21) ? 32'h0000_0FFF :
                      (n == 32'd25) ? 32'h0000_0001 : 32'h8000_0000;
      default: return (n == 32'd21) ? 32'h0000_0005 : 32'h8000_0000;
    endcase
  endfunction

  // Memory model with one-cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) mem_read_data <= mem[mem_addr[7:0]];

  // Core model: drops done on start, writes results and raises done later.
  int          core_timer = 0;
  logic [31:0] core_base = '0;
  always @(posedge clk) begin
    if (core_start) begin
      core_done  <= 1'b0;
      core_base  <= core_nonce_base;
      core_timer <= CORE_LAT;
    end else if (core_timer > 0) begin
      core_timer <= core_timer - 1;
      if (core_timer == 1) begin
        for (int i = 0; i < 16; i++)
          mem[8'(OUT_ADDR) + 8'(i)] <= word_of(core_base + 32'(i), pattern);
        core_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor / scoreboard.
  int   starts_seen = 0;
  int   memcyc_seen = 0;
  logic done_seen = 1'b0;
  logic prev_done = 1'b0;
  logic overlap = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      starts_seen = 0;
      memcyc_seen = 0;
      done_seen   = 1'b0;
      overlap     = 1'b0;
    end else begin
      if (sweep_start && !busy) begin
        starts_seen = 0;
        memcyc_seen = 0;
        done_seen   = 1'b0;
        overlap     = 1'b0;
      end
      if (core_start) begin
        starts_seen++;
        done_seen = 1'b0;
      end
      if (mem_sel) memcyc_seen++;
      if (mem_sel && core_start) overlap = 1'b1;
      if (core_done && !prev_done) done_seen = 1'b1;
      if (sweep_done) begin
        exp_t e;
        sweep_no++;
        $display("sweep %0d: found=%0d nonce=%h hash=%h batches=%0d starts=%0d memcyc=%0d",
                 sweep_no, found, found_nonce, found_hash, batch_count, starts_seen, memcyc_seen);
        if (exp_q.size() == 0) begin
          chk("unexpected_sweep_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("found",        32'(found), 32'(e.found));
          chk("found_nonce",  found_nonce, e.nonce);
          chk("found_hash",   found_hash, e.hash);
          chk("batch_count",  32'(batch_count), 32'(e.batches));
          chk("core_starts",  32'(starts_seen), 32'(e.starts));
          chk("mem_sel_cyc",  32'(memcyc_seen), 32'(e.memcyc));
          chk("done_before_finish", 32'(done_seen), 32'd1);
          chk("port_overlap", 32'(overlap), 32'd0);
          chk("busy_at_done", 32'(busy), 32'd1);
        end
      end
    end
    prev_done = core_done;
  end

  // mode 0: plain, 1: extra sweep_start while busy, 2: abort in WAIT_CORE
  task automatic run_sweep(input logic [31:0] first, input logic [31:0] last,
                           input logic [31:0] tgt, input int pat, input int mode,
                           input exp_t e);
    int n;
    pattern = pat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    nonce_first = first; nonce_last = last; target = tgt; sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1;
      nonce_first = 32'd500; nonce_last = 32'd600; target = '1; sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
    end
    if (mode == 2) begin
      n = 0;
      while (!core_start && n < 100) begin @(negedge clk); n++; end
      if (!core_start) chk("launch_timeout", 32'd1, 32'd0);
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!sweep_done && n < 3000);
    if (!sweep_done) chk("sweep_done_timeout", 32'd1, 32'd0);
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("found_held", 32'(found), 32'(e.found));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},        32'(busy), 32'd0);
    chk({tag, "_mem_sel"},     32'(mem_sel), 32'd0);
    chk({tag, "_core_start"},  32'(core_start), 32'd0);
    chk({tag, "_sweep_done"},  32'(sweep_done), 32'd0);
    chk({tag, "_found"},       32'(found), 32'd0);
    chk({tag, "_mem_addr"},    32'(mem_addr), 32'd0);
    chk({tag, "_batch_count"}, 32'(batch_count), 32'd0);
    chk({tag, "_nonce_base"},  core_nonce_base, 32'd0);
    chk({tag, "_found_nonce"}, found_nonce, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_sweep(32'd0, 32'd15, 32'hFFFF_FFFF, 0, 0, '{1'b1, 32'd0, 32'h0000_1000, 16'd1, 1, 17});
    run_sweep(32'd0, 32'd47, 32'h0000_1000, 1, 1, '{1'b1, 32'd21, 32'h0000_0FFF, 16'd2, 2, 34});
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 2, 0, '{1'b0, 32'd0, 32'd0, 16'd1, 1, 17});
    run_sweep(32'd10, 32'd20, 32'hFFFF_FFFF, 0, 0, '{1'b1, 32'd10, 32'h0000_100A, 16'd1, 1, 17});
    run_sweep(32'd16, 32'd20, 32'h100, 2, 0, '{1'b0, 32'd0, 32'd0, 16'd1, 1, 17});
    run_sweep(32'd0, 32'd1000, 32'hFFFF_FFFF, 0, 2, '{1'b0, 32'd0, 32'd0, 16'd0, 1, 0});
    run_sweep(32'd0, 32'd40, 32'h10, 0, 0, '{1'b0, 32'd0, 32'd0, 16'd3, 3, 51});
    run_sweep(32'd100, 32'd50, 32'hFFFF_FFFF, 0, 0, '{1'b0, 32'd0, 32'd0, 16'd1, 1, 17});
    run_sweep(32'd0, 32'd15, 32'd0, 0, 0, '{1'b0, 32'd0, 32'd0, 16'd1, 1, 17});

    // Reset in the middle of readback, after a hit has been latched.
    pattern = 0;
    @(posedge clk); #1;
    nonce_first = 32'd0; nonce_last = 32'd15; target = 32'hFFFF_FFFF; sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    n = 0;
    while (!mem_sel && n < 200) begin @(posedge clk); #1; n++; end
    if (!mem_sel) chk("readback_timeout", 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_found", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_sweep(32'd0, 32'd15, 32'hFFFF_FFFF, 0, 0, '{1'b1, 32'd0, 32'h0000_1000, 16'd1, 1, 17});

    chk("pending_expect", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
